data_memory_unit: RTL and testbench

DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

---
 rtl/data_memory_pkg.sv | 22 ++
 rtl/data_ram.sv | 33 +++
 rtl/data_memory_unit.sv | 148 ++++++++++++++
 tb/tb_data_memory_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// ============================================================================
// data_memory_pkg : shared state encoding and default geometry for the
//                   scalar/vector data memory unit.
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_memory_pkg;

    localparam int DEF_N     = 24;
    localparam int DEF_LANES = 8;
    localparam int DEF_DEPTH = 16384;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VLOAD  = 2'd1,
        VSTORE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// data_ram : single-port DEPTH x N word array, synchronous write, read data
//            presented combinationally so the caller registers it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram #(
    parameter int N     = 24,
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [N-1:0]  wdata_i,
    output logic [N-1:0]  rdata_o
);

    logic [N-1:0] mem_q [DEPTH];

    // Read sees the pre-edge contents, giving read-before-write at the caller.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_memory_unit.sv
// ============================================================================
// data_memory_unit : scalar and multi-lane vector load/store front end over
//                    one shared single-port data array.
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_unit
    import data_memory_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         scalar_data_address,
    input  logic [N-1:0]         write_scalar_data,
    input  logic                 ScalarMemRead,
    input  logic                 ScalarMemWrite,
    input  logic [N-1:0]         vector_data_address,
    input  logic [N*LANES-1:0]   write_vector_data,
    input  logic                 VectorMemRead,
    input  logic                 VectorMemWrite,
    output logic [N-1:0]         scalar_data_read,
    output logic [N*LANES-1:0]   vector_data,
    output logic                 busy,
    output logic                 vector_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_e               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [AW-1:0]        base_q, base_d;
    logic [N*LANES-1:0]   wvec_q, wvec_d;
    logic [N-1:0]         sdr_q, sdr_d;
    logic [N*LANES-1:0]   vdata_q, vdata_d;
    logic                 done_q, done_d;

    logic                 w_ram_we;
    logic [AW-1:0]        w_ram_addr;
    logic [N-1:0]         w_ram_wdata;
    logic [N-1:0]         w_ram_rdata;
    logic [AW:0]          w_vsum;
    logic [AW-1:0]        w_vaddr;
    logic                 w_last_lane;
    logic                 w_unused_addr_bits;

    assign w_unused_addr_bits = &{1'b0, scalar_data_address[N-1:AW],
                                  vector_data_address[N-1:AW]};

    // Lane address wraps modulo DEPTH even when DEPTH is not a power of two.
    assign w_vsum      = {1'b0, base_q} + (AW+1)'(lane_q);
    assign w_vaddr     = (w_vsum >= (AW+1)'(DEPTH)) ? AW'(w_vsum - (AW+1)'(DEPTH))
                                                    : AW'(w_vsum);
    assign w_last_lane = (lane_q == LW'(LANES - 1));

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        base_d      = base_q;
        wvec_d      = wvec_q;
        sdr_d       = sdr_q;
        vdata_d     = vdata_q;
        done_d      = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = scalar_data_address[AW-1:0];
        w_ram_wdata = write_scalar_data;

        case (state_q)
            IDLE: begin
                if (VectorMemWrite || VectorMemRead) begin
                    state_d = VectorMemWrite ? VSTORE : VLOAD;
                    lane_d  = '0;
                    base_d  = vector_data_address[AW-1:0];
                    wvec_d  = write_vector_data;
                end else begin
                    if (ScalarMemRead) begin
                        sdr_d = w_ram_rdata;
                    end
                    w_ram_we = ScalarMemWrite;
                end
            end
            VLOAD, VSTORE: begin
                w_ram_addr = w_vaddr;
                if (state_q == VLOAD) begin
                    vdata_d[lane_q*N +: N] = w_ram_rdata;
                end else begin
                    w_ram_we    = 1'b1;
                    w_ram_wdata = wvec_q[lane_q*N +: N];
                end
                if (w_last_lane) begin
                    state_d = IDLE;
                    lane_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            base_q  <= '0;
            wvec_q  <= '0;
            sdr_q   <= '0;
            vdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            base_q  <= base_d;
            wvec_q  <= wvec_d;
            sdr_q   <= sdr_d;
            vdata_q <= vdata_d;
            done_q  <= done_d;
        end
    end

    data_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (w_ram_we & ~rst),
        .addr_i  (w_ram_addr),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    assign scalar_data_read = sdr_q;
    assign vector_data      = vdata_q;
    assign busy             = (state_q != IDLE);
    assign vector_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
// ============================================================================
// tb_data_memory_unit : directed table-driven and sequence checks for
//                       data_memory_unit at N=24, LANES=8, DEPTH=16384.
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_unit;

    localparam int N     = 24;
    localparam int LANES = 8;
    localparam int DEPTH = 16384;
    localparam int VW    = N * LANES;

    logic            clk;
    logic            rst;
    logic [N-1:0]    scalar_data_address;
    logic [N-1:0]    write_scalar_data;
    logic            ScalarMemRead;
    logic            ScalarMemWrite;
    logic [N-1:0]    vector_data_address;
    logic [VW-1:0]   write_vector_data;
    logic            VectorMemRead;
    logic            VectorMemWrite;
    logic [N-1:0]    scalar_data_read;
    logic [VW-1:0]   vector_data;
    logic            busy;
    logic            vector_done;

    int n_vec;
    int n_err;

    data_memory_unit #(
        .N     (N),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .scalar_data_address (scalar_data_address),
        .write_scalar_data   (write_scalar_data),
        .ScalarMemRead       (ScalarMemRead),
        .ScalarMemWrite      (ScalarMemWrite),
        .vector_data_address (vector_data_address),
        .write_vector_data   (write_vector_data),
        .VectorMemRead       (VectorMemRead),
        .VectorMemWrite      (VectorMemWrite),
        .scalar_data_read    (scalar_data_read),
        .vector_data         (vector_data),
        .busy                (busy),
        .vector_done         (vector_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic         re;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        logic [N-1:0] exp_sdr;
    } svec_t;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ScalarMemRead  = 1'b0;
        ScalarMemWrite = 1'b0;
        VectorMemRead  = 1'b0;
        VectorMemWrite = 1'b0;
    endtask

    // One scalar request cycle; outputs are valid 1 time unit after the edge.
    task automatic sop(input logic we, input logic re, input logic [N-1:0] addr, input logic [N-1:0] wd);
        @(negedge clk);
        scalar_data_address = addr;
        write_scalar_data   = wd;
        ScalarMemWrite      = we;
        ScalarMemRead       = re;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic sread_check(input string name, input logic [N-1:0] addr, input logic [N-1:0] exp);
        sop(1'b0, 1'b1, addr, '0);
        check(name, VW'(scalar_data_read), VW'(exp));
    endtask

    // Vector request plus optional scalar requests held until busy drops.
    task automatic vec_run(input string name, input logic vw, input logic vr,
                           input logic [N-1:0] base, input logic [VW-1:0] wv,
                           input logic sw, input logic sr,
                           input logic [N-1:0] saddr, input logic [N-1:0] sdata);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        vector_data_address = base;
        write_vector_data   = wv;
        VectorMemWrite      = vw;
        VectorMemRead       = vr;
        scalar_data_address = saddr;
        write_scalar_data   = sdata;
        ScalarMemWrite      = sw;
        ScalarMemRead       = sr;
        @(posedge clk);
        #1;
        VectorMemWrite = 1'b0;
        VectorMemRead  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (vector_done === 1'b1) done_cnt++;
            if (busy !== 1'b1) idle_inputs();
            @(posedge clk);
            #1;
        end
        idle_inputs();
        check({name, " busy cycles"}, VW'(busy_cnt), VW'(LANES));
        check({name, " done pulses"}, VW'(done_cnt), VW'(1));
    endtask

    svec_t         tbl [9];
    logic [VW-1:0] exp_v;
    logic [VW-1:0] wv;
    logic [N-1:0]  exp_sdr;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        scalar_data_address = '0;
        write_scalar_data   = '0;
        vector_data_address = '0;
        write_vector_data   = '0;
        idle_inputs();

        tbl[0] = '{1'b1, 1'b0, 24'h000010, 24'hABCDEF, 24'h000000};
        tbl[1] = '{1'b0, 1'b1, 24'h000010, 24'h000000, 24'hABCDEF};
        tbl[2] = '{1'b1, 1'b0, 24'h000020, 24'h000111, 24'hABCDEF};
        tbl[3] = '{1'b1, 1'b1, 24'h000020, 24'h000222, 24'h000111};
        tbl[4] = '{1'b0, 1'b1, 24'h000020, 24'h000000, 24'h000222};
        tbl[5] = '{1'b0, 1'b0, 24'h000010, 24'h000000, 24'h000222};
        tbl[6] = '{1'b1, 1'b0, 24'h003FFF, 24'h7FFFFF, 24'h000222};
        tbl[7] = '{1'b0, 1'b1, 24'h003FFF, 24'h000000, 24'h7FFFFF};
        tbl[8] = '{1'b0, 1'b1, 24'h004010, 24'h000000, 24'hABCDEF};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset sdr",   VW'(scalar_data_read), '0);
        check("reset vdata", vector_data, '0);
        check("reset busy",  VW'(busy), '0);
        check("reset done",  VW'(vector_done), '0);

        for (int i = 0; i < 9; i++) begin
            sop(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
            check($sformatf("scalar vec %0d sdr", i), VW'(scalar_data_read), VW'(tbl[i].exp_sdr));
            check($sformatf("scalar vec %0d busy", i), VW'(busy), '0);
        end

        // Vector store then load at 0x0100.
        for (int k = 0; k < LANES; k++) wv[k*N +: N] = N'(k + 1);
        vec_run("vstore 0x100", 1'b1, 1'b0, 24'h000100, wv, 1'b0, 1'b0, '0, '0);
        vec_run("vload 0x100",  1'b0, 1'b1, 24'h000100, '0, 1'b0, 1'b0, '0, '0);
        check("vload 0x100 data", vector_data, wv);
        for (int k = 0; k < LANES; k++)
            sread_check($sformatf("scalar 0x%h", 16'h0100 + k), N'(32'h100 + k), N'(k + 1));

        // Wrap-around store at 0x3FFC.
        for (int k = 0; k < LANES; k++) wv[k*N +: N] = N'(32'hA00000 + k);
        vec_run("vstore wrap", 1'b1, 1'b0, 24'h003FFC, wv, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++)
            sread_check($sformatf("wrap hi lane %0d", k), N'(32'h3FFC + k), N'(32'hA00000 + k));
        for (int k = 4; k < LANES; k++)
            sread_check($sformatf("wrap lo lane %0d", k), N'(k - 4), N'(32'hA00000 + k));
        vec_run("vload wrap", 1'b0, 1'b1, 24'h003FFC, '0, 1'b0, 1'b0, '0, '0);
        check("vload wrap data", vector_data, wv);

        // Scalar requests while busy, and in the vector accept cycle, are dropped.
        sop(1'b1, 1'b0, 24'h000200, 24'h0000AA);
        sop(1'b1, 1'b0, 24'h000201, 24'h000BBB);
        sread_check("pre busy sdr", 24'h000010, 24'hABCDEF);
        vec_run("vstore 0x300", 1'b1, 1'b0, 24'h000300, wv, 1'b1, 1'b1, 24'h000200, 24'h123456);
        check("sdr held while busy", VW'(scalar_data_read), VW'(24'hABCDEF));
        sread_check("0x200 unchanged", 24'h000200, 24'h0000AA);
        for (int k = 0; k < LANES; k++) exp_v[k*N +: N] = N'(k + 1);
        vec_run("vload+swrite", 1'b0, 1'b1, 24'h000100, '0, 1'b1, 1'b0, 24'h000201, 24'h555555);
        check("vload+swrite data", vector_data, exp_v);
        sread_check("0x201 unchanged", 24'h000201, 24'h000BBB);

        // Both vector requests: store wins.
        for (int k = 0; k < LANES; k++) wv[k*N +: N] = N'(32'h0D0000 + k);
        vec_run("vrd+vwr", 1'b1, 1'b1, 24'h000500, wv, 1'b0, 1'b0, '0, '0);
        check("vrd+vwr vdata held", vector_data, exp_v);
        sread_check("vrd+vwr lane7", 24'h000507, 24'h0D0007);

        // Reset after E3 of a vector store.
        for (int k = 0; k < LANES; k++) sop(1'b1, 1'b0, N'(32'h400 + k), '0);
        for (int k = 0; k < LANES; k++) wv[k*N +: N] = N'(32'h0C0000 + k + 1);
        @(negedge clk);
        vector_data_address = 24'h000400;
        write_vector_data   = wv;
        VectorMemWrite      = 1'b1;
        @(posedge clk);
        #1;
        VectorMemWrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst mid busy",  VW'(busy), '0);
        check("rst mid vdata", vector_data, '0);
        check("rst mid sdr",   VW'(scalar_data_read), '0);
        begin
            int dcnt;
            dcnt = 0;
            for (int i = 0; i < 10; i++) begin
                if (vector_done === 1'b1) dcnt++;
                @(posedge clk);
                #1;
            end
            check("rst mid no done", VW'(dcnt), '0);
        end
        for (int k = 0; k < LANES; k++) begin
            exp_sdr = (k < 3) ? N'(32'h0C0000 + k + 1) : '0;
            sread_check($sformatf("rst mid lane %0d", k), N'(32'h400 + k), exp_sdr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
